// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared instruction-cache address layout, FSM states and field widths
package cpu_types_pkg;
  localparam int ITAG_W = 25;
  localparam int IIDX_W = 4;
  localparam int IBLK_W = 1;
  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [IBLK_W-1:0] blkoff;
    logic [1:0]        bytoff;
  } icachef_t;
  typedef enum logic [1:0] {IDLE, FETCH0, FETCH1, COMMIT} icache_state_t;
endpackage

// File: rtl/icache_frames.sv
// icache_frames: valid/tag/data frame storage, combinational read, synchronous whole-frame write
module icache_frames
  import cpu_types_pkg::*;
#(
  parameter int SETS  = 16,
  parameter int WORDS = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [IIDX_W-1:0]       ridx,
  output logic                    rvalid,
  output logic [ITAG_W-1:0]       rtag,
  output logic [WORDS-1:0][31:0]  rdata,
  input  logic                    wen,
  input  logic [IIDX_W-1:0]       widx,
  input  logic [ITAG_W-1:0]       wtag,
  input  logic [WORDS-1:0][31:0]  wdata
);
  logic [SETS-1:0]                   valid;
  logic [SETS-1:0][ITAG_W-1:0]       tags;
  logic [SETS-1:0][WORDS-1:0][31:0]  data;
  assign rvalid = valid[ridx];
  assign rtag   = tags[ridx];
  assign rdata  = data[ridx];
  // reset wins over a same-cycle write so a fill interrupted at COMMIT is dropped
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid <= '0;
      tags  <= '0;
      data  <= '0;
    end else if (wen) begin
      valid[widx] <= 1'b1;
      tags[widx]  <= wtag;
      data[widx]  <= wdata;
    end
  end
endmodule

// File: rtl/icache.sv
// icache: direct-mapped two-word-block instruction cache; ICACHE_STATS_EN adds hit/miss counters
module icache
  import cpu_types_pkg::*;
#(
  parameter int SETS  = 16,
  parameter int WORDS = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  icache_state_t             state, nxt;
  icachef_t                  fa;
  logic [ITAG_W-1:0]         ltag, rtag;
  logic [IIDX_W-1:0]         lidx;
  logic [WORDS-1:0][31:0]    wbuf, rdata;
  logic                      rvalid, miss, unused_bytoff;
  assign fa            = imemaddr;
  assign unused_bytoff = ^fa.bytoff;
  assign ihit          = state == IDLE && imemREN && rvalid && rtag == fa.tag;
  assign miss          = state == IDLE && imemREN && !ihit;
  assign imemload      = ihit ? rdata[fa.blkoff] : '0;
  icache_frames #(.SETS(SETS), .WORDS(WORDS)) u_frames (
    .CLK(CLK), .RST(RST),
    .ridx(fa.idx), .rvalid(rvalid), .rtag(rtag), .rdata(rdata),
    .wen(state == COMMIT), .widx(lidx), .wtag(ltag), .wdata(wbuf)
  );
  always_comb begin
    nxt   = state;
    iREN  = state == FETCH0 || state == FETCH1;
    iaddr = iREN ? {ltag, lidx, state == FETCH1, 2'b00} : '0;
    unique case (state)
      IDLE:    nxt = miss ? FETCH0 : IDLE;
      FETCH0:  nxt = iwait ? FETCH0 : FETCH1;
      FETCH1:  nxt = iwait ? FETCH1 : COMMIT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      ltag  <= '0;
      lidx  <= '0;
      wbuf  <= '0;
    end else begin
      state <= nxt;
      if (miss) begin
        ltag <= fa.tag;
        lidx <= fa.idx;
      end
      if (state == FETCH0 && !iwait) wbuf[0] <= iload;
      if (state == FETCH1 && !iwait) wbuf[1] <= iload;
    end
  end
`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ihit) hit_count <= hit_count + 32'd1;
      if (miss) miss_count <= miss_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed plus random stimulus against a frame-array/fill-progress reference model
module tb_icache;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = '0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b0;
  logic [31:0] iload = '0;
  logic [31:0] hit_count, miss_count;
  int n_tests = 0;
  int n_fail  = 0;

  icache dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload)
`ifdef ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );
`ifndef ICACHE_STATS_EN
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

  always #5 CLK = ~CLK;

  // reference: cached frames plus the progress of the one outstanding fill
  bit          m_valid [16];
  logic [24:0] m_tag   [16];
  logic [31:0] m_data  [16][2];
  int          fill_pos;            // -1 none, 0/1 word being fetched, 2 writing
  logic [31:0] fill_base;
  logic [31:0] fill_buf [2];
  logic [31:0] m_hits, m_misses;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h20010001;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_valid[i]) m_valid[i] = 0;
    fill_pos = -1;
    m_hits = '0;
    m_misses = '0;
  endtask

  function automatic bit model_hit(input logic ren, input logic [31:0] a);
    return fill_pos < 0 && ren && m_valid[a[6:3]] && m_tag[a[6:3]] == a[31:7];
  endfunction

  task automatic step(input logic ren, input logic [31:0] a, input logic w, input logic r);
    logic        eh;
    logic [31:0] el, ea;
    @(negedge CLK);
    RST = r;
    imemREN = ren;
    imemaddr = a;
    iwait = w;
    iload = (fill_pos == 0 || fill_pos == 1) && !w ? mem_word(fill_base + 32'(fill_pos * 4)) : $urandom;
    #1;
    eh = model_hit(ren, a);
    el = eh ? m_data[a[6:3]][a[2]] : '0;
    ea = (fill_pos == 0 || fill_pos == 1) ? fill_base + 32'(fill_pos * 4) : '0;
    check("ihit", 32'(ihit), 32'(eh));
    check("imemload", imemload, el);
    check("iREN", 32'(iREN), 32'(fill_pos == 0 || fill_pos == 1));
    check("iaddr", iaddr, ea);
`ifdef ICACHE_STATS_EN
    check("hit_count", hit_count, m_hits);
    check("miss_count", miss_count, m_misses);
`endif
    @(posedge CLK);
    if (r) model_reset();
    else if (fill_pos < 0) begin
      if (eh) m_hits++;
      else if (ren) begin
        fill_base = a & ~32'h7;
        fill_pos = 0;
        m_misses++;
      end
    end else if (fill_pos < 2) begin
      if (!w) begin
        fill_buf[fill_pos] = iload;
        fill_pos++;
      end
    end else begin
      m_valid[fill_base[6:3]] = 1;
      m_tag[fill_base[6:3]] = fill_base[31:7];
      m_data[fill_base[6:3]][0] = fill_buf[0];
      m_data[fill_base[6:3]][1] = fill_buf[1];
      fill_pos = -1;
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge CLK);
    // cold miss, spatial hit
    repeat (5) step(1, 32'h40, 0, 0);
    step(1, 32'h44, 0, 0);
    // conflict on index 8 and re-miss of the evicted block
    repeat (5) step(1, 32'h840, 0, 0);
    repeat (5) step(1, 32'h40, 0, 0);
    // memory wait in FETCH0
    step(1, 32'h140, 0, 0);
    repeat (3) step(1, 32'h140, 1, 0);
    repeat (4) step(1, 32'h140, 0, 0);
    // address change mid-fill
    step(1, 32'h48, 0, 0);
    step(1, 32'h48, 0, 0);
    step(1, 32'h100, 0, 0);
    repeat (6) step(1, 32'h100, 0, 0);
    // reset in FETCH1, then 0x40 misses
    step(1, 32'h240, 0, 0);
    step(1, 32'h240, 0, 0);
    step(1, 32'h240, 0, 1);
    repeat (5) step(1, 32'h40, 0, 0);
    step(0, 32'h40, 0, 0);
    // random traffic over a small tag pool to create hits and conflicts
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 7) != 0,
           32'($urandom_range(0, 2)) << 7 | 32'($urandom_range(0, 15)) << 3 | 32'($urandom_range(0, 7)),
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 99) == 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/icache.md
# icache

Direct-mapped, two-word-block instruction cache between the pipeline's instruction fetch port and the memory controller's instruction port. It returns hit data combinationally in the cycle a fetch address is presented. On a miss it stalls the fetch stage, fills the block from memory in two word transfers, then hits. The fetch stage advances the PC only on a hit, so the cache owns all instruction-side stall timing.

## Interface
Parameters:
- SETS, 16: number of frames; power of two; index width = log2(SETS).
- WORDS, 2: words per block; fixed at 2 for this revision.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high.
- imemREN  in  1  fetch request from pipeline.
- imemaddr  in  32  fetch byte address; bits [1:0] ignored.
- ihit  out  1  requested word valid this cycle.
- imemload  out  32  instruction word; 0 when ihit low.
- iREN  out  1  read request to memory controller.
- iaddr  out  32  word-aligned memory read address.
- iwait  in  1  memory busy; data valid in the cycle iwait is low while iREN is high.
- iload  in  32  memory read data.
- hit_count  out  32  present only with ICACHE_STATS_EN.
- miss_count  out  32  present only with ICACHE_STATS_EN.

## Operation
- Address split for SETS=16: tag [31:7] (25b), index [6:3], block offset [2], byte offset [1:0].
- Frame: valid bit, tag, two data words.
- Hit = imemREN && valid[idx] && tag[idx]==addr.tag. imemload = data[idx][blkoff] on hit, else 0.
- FSM states: IDLE, FETCH0, FETCH1, COMMIT.
- IDLE: iREN=0. If imemREN && !hit, latch the miss tag and index, then go to FETCH0. Otherwise stay.
- FETCH0: iREN=1, iaddr={ltag,lidx,1'b0,2'b00}. When iwait=0, capture iload into word buffer 0 and go to FETCH1.
- FETCH1: iREN=1, iaddr={ltag,lidx,1'b1,2'b00}. When iwait=0, capture into word buffer 1 and go to COMMIT.
- COMMIT: write both words, the tag, and valid=1 into frame lidx; iREN=0; go to IDLE.
- ihit is 0 in every non-IDLE state, even if the current address matches an existing frame.
- The fill always uses the latched address. Changes on imemaddr during the fill are ignored. After COMMIT, the current imemaddr is re-evaluated in IDLE.
- A miss on the same index replaces the old frame. No replacement choice exists.
- imemREN low in IDLE: no miss is started and ihit=0.

## Timing
- Hit latency: 0 cycles (combinational from imemaddr and frame state).
- Miss with zero-wait memory: miss seen in cycle n; FETCH0 at n+1; FETCH1 at n+2; COMMIT at n+3; hit at n+4.
- Each extra iwait cycle extends the fill by one cycle. iaddr is held stable while iwait=1.
- Reset values: all valid bits 0; state IDLE; ihit 0; imemload 0; iREN 0; iaddr 0; word buffers 0; counters 0.
- RST asserted mid-fill: at the next edge the state returns to IDLE, iREN drops, and the partial block is discarded with no frame written.
- RST has priority over the COMMIT write in the same cycle.

## Configuration
- ICACHE_STATS_EN defined:
  - hit_count increments on each IDLE cycle with imemREN && hit.
  - miss_count increments on each IDLE→FETCH0 transition.
  - Both counters are 32-bit, wrap from 0xFFFFFFFF to 0, and clear on RST.
- ICACHE_STATS_EN undefined: the counters and their ports are absent; the rest of the behaviour is identical.

## Structure
- The shared package (cpu_types_pkg) holds:
  - icachef_t packed struct {tag, idx, blkoff, bytoff};
  - icache_state_t enum;
  - constants ITAG_W, IIDX_W, IBLK_W.
- One sub-module, icache_frames: valid/tag/data storage with one combinational read port and one synchronous whole-frame write port, cleared on RST.
- The FSM, address latch, word buffers, and counters stay in icache.

## Test plan
- Cold miss: RST, then imemaddr=0x00000040, iwait=0, iload=0x20010001 then 0x20020002 → iREN high for 2 cycles with iaddr 0x40 then 0x44; ihit=1 with imemload=0x20010001 in cycle n+4.
- Spatial hit: after the cold miss, imemaddr=0x00000044 → ihit=1 and imemload=0x20020002 in the same cycle, iREN=0.
- Conflict: fill 0x40, then fetch 0x00000840 (same index, new tag) → miss and refill; a later fetch of 0x40 misses again.
- Memory wait: iwait held 1 for 3 cycles in FETCH0 → iaddr stays 0x40, no capture; completion at n+7.
- Address change mid-fill: imemaddr moves to 0x100 during FETCH1 → frame for 0x40 is still committed, then 0x100 starts a new miss.
- Reset mid-fill: RST in FETCH1 → next cycle IDLE, iREN=0, a fetch of 0x40 misses; with ICACHE_STATS_EN, miss_count reads 0 after reset.
